tree_stage_param: RTL and testbench

Parametrised decision-tree pipeline stage, one per tree level. It takes a sample vector (from the left) and a node index (from the top), and fetches that node's record from level memory with a configurable fixed latency. As a branch it produces the child index; as a leaf it produces the weighted result. Its output handshake forks to the bottom and right consumers, and each side is released independently.

---
 rtl/tree_stage_param.sv | 172 +++++++++++++++++
 tb/tb_tree_stage_param.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tree_stage_param.sv
// One decision-tree level: fetch a node record, evaluate it as a branch or a leaf, and
// present the result to the bottom and right consumers until each has taken it.
module tree_stage_param #(
    parameter int unsigned SAMPLE_SIZE = 8,
    parameter int unsigned NUM_NODES   = 32,
    parameter int unsigned DATA_SIZE   = 32,
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned LEAF        = 0,
    parameter int unsigned SIGNED_CMP  = 0,
    localparam int unsigned IW = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             memRdy,
    input  logic                             validIdx,
    input  logic                             validSamp,
    output logic                             received,
    input  logic [SAMPLE_SIZE*DATA_SIZE-1:0] samplesIn,
    input  logic [IW-1:0]                    nodeIdxIn,
    output logic [IW-1:0]                    memReqOut,
    output logic                             memReqValid,
    input  logic [3*DATA_SIZE-1:0]           memBusIn,
    output logic [SAMPLE_SIZE*DATA_SIZE-1:0] samplesOut,
    output logic [IW:0]                      nodeIdxOut,
    output logic [DATA_SIZE-1:0]             dataOut,
    output logic                             errIdx,
    output logic                             validBottom,
    output logic                             validRight,
    input  logic                             bottomRec,
    input  logic                             rightRec
);

    localparam int unsigned SW = SAMPLE_SIZE * DATA_SIZE;
    localparam logic [3:0] CNT_INIT = (MEM_LATENCY > 0) ? 4'(MEM_LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {StIdle, StWait, StHold} state_e;

    state_e               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [SW-1:0]        samp_q;
    logic [IW-1:0]        idx_q;
    logic                 b_done_q, b_done_d, r_done_q, r_done_d;
    logic [IW:0]          node_idx_q;
    logic [DATA_SIZE-1:0] data_q;
    logic                 err_q;

    logic                 accept, capture, b_take, r_take;
    logic [SW-1:0]        cur_samp;
    logic [IW-1:0]        cur_idx;
    logic [DATA_SIZE-1:0] f_sidx, f_mid, f_off, cur, mac;
    logic                 f_err, gt;
    logic [IW:0]          node_idx_res;
    logic [DATA_SIZE-1:0] data_res;

    // Asserting rst forces every combinational output low as well.
    assign accept = (state_q == StIdle) & memRdy & validIdx & validSamp & ~rst;

    // With zero latency the record arrives in the accept cycle, before anything is latched.
    assign cur_samp = (MEM_LATENCY == 0) ? samplesIn : samp_q;
    assign cur_idx  = (MEM_LATENCY == 0) ? nodeIdxIn : idx_q;

    assign f_sidx = memBusIn[3*DATA_SIZE-1:2*DATA_SIZE];
    assign f_mid  = memBusIn[2*DATA_SIZE-1:DATA_SIZE];
    assign f_off  = memBusIn[DATA_SIZE-1:0];
    assign f_err  = (f_sidx >= DATA_SIZE'(SAMPLE_SIZE));

    always_comb begin
        cur = '0;
        for (int unsigned i = 0; i < SAMPLE_SIZE; i++) begin
            if (f_sidx == DATA_SIZE'(i)) cur = cur_samp[i*DATA_SIZE +: DATA_SIZE];
        end
    end

    always_comb begin
        if (SIGNED_CMP != 0) gt = $signed(cur) > $signed(f_mid);
        else                 gt = cur > f_mid;
    end

    // Truncated product bits are identical for signed and unsigned operands.
    assign mac = cur * f_mid + f_off;

    assign node_idx_res = (LEAF != 0) ? '0 : {cur_idx, gt};
    assign data_res     = (LEAF != 0) ? mac : '0;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        b_done_d    = b_done_q;
        r_done_d    = r_done_q;
        capture     = 1'b0;
        received    = 1'b0;
        memReqValid = 1'b0;
        memReqOut   = '0;
        validBottom = 1'b0;
        validRight  = 1'b0;
        b_take      = 1'b0;
        r_take      = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    received    = 1'b1;
                    memReqValid = 1'b1;
                    memReqOut   = nodeIdxIn;
                    if (MEM_LATENCY == 0) begin
                        capture = 1'b1;
                        state_d = StHold;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    capture = 1'b1;
                    state_d = StHold;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StHold: begin
                validBottom = ~b_done_q;
                validRight  = ~r_done_q;
                b_take      = validBottom & bottomRec;
                r_take      = validRight & rightRec;
                if ((b_done_q | b_take) & (r_done_q | r_take)) begin
                    state_d  = StIdle;
                    b_done_d = 1'b0;
                    r_done_d = 1'b0;
                end else begin
                    b_done_d = b_done_q | b_take;
                    r_done_d = r_done_q | r_take;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            samp_q     <= '0;
            idx_q      <= '0;
            b_done_q   <= 1'b0;
            r_done_q   <= 1'b0;
            node_idx_q <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            b_done_q <= b_done_d;
            r_done_q <= r_done_d;
            if (accept) begin
                samp_q <= samplesIn;
                idx_q  <= nodeIdxIn;
            end
            if (capture) begin
                node_idx_q <= node_idx_res;
                data_q     <= data_res;
                err_q      <= f_err;
            end
        end
    end

    assign samplesOut = samp_q;
    assign nodeIdxOut = node_idx_q;
    assign dataOut    = data_q;
    assign errIdx     = err_q;

endmodule

// File: tb/tb_tree_stage_param.sv
// Four stage instances (branch/leaf x unsigned/signed, varied latency) driven with random
// and table items; a per-lane monitor pops expected results as the fork outputs appear.
module tb_tree_stage_param;

    localparam int unsigned NL = 4;
    localparam int unsigned SS = 8;
    localparam int unsigned NN = 32;
    localparam int unsigned D  = 8;
    localparam int unsigned IW = 5;
    localparam int unsigned SW = SS * D;

    localparam logic [3:0]  LEAF_V = 4'b1100;
    localparam logic [3:0]  SIGN_V = 4'b1010;
    localparam logic [15:0] ML_V   = {4'd2, 4'd0, 4'd3, 4'd1};

    localparam logic [7:0]    D_VAL  [6] = '{8'd40, 8'd3, 8'd20, 8'hFE, 8'hFF, 8'h11};
    localparam logic [7:0]    D_SIDX [6] = '{8'd2, 8'd0, 8'd1, 8'd3, 8'd4, 8'd9};
    localparam logic [7:0]    D_MID  [6] = '{8'd30, 8'd4, 8'd20, 8'd5, 8'd0, 8'd30};
    localparam logic [7:0]    D_OFF  [6] = '{8'd0, 8'd7, 8'd0, 8'd1, 8'd0, 8'd2};
    localparam logic [IW-1:0] D_IDX  [6] = '{5'd5, 5'd1, 5'd2, 5'd3, 5'd4, 5'd6};

    typedef struct {
        logic [IW:0]   idx;
        logic [D-1:0]  data;
        logic          err;
        logic [SW-1:0] samp;
        longint        cyc;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst_init, rst_mid, rst_go;
    wire    rst = rst_init | rst_mid;
    longint cyc = 0;
    int     n_tests = 0;
    int     n_fail = 0;

    logic [NL-1:0] zero_v, done_v, done2_v;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got no/unexpected event, want expected event", name);
    endtask

    for (genvar g = 0; g < NL; g++) begin : g_lane
        localparam int unsigned ML = ML_V[g*4 +: 4];
        localparam bit LF = LEAF_V[g];
        localparam bit SG = SIGN_V[g];

        logic          mem_rdy, valid_idx, valid_samp, received, mem_req_valid, err_idx;
        logic          valid_bottom, valid_right, bottom_rec, right_rec;
        logic [SW-1:0] samples_in, samples_out;
        logic [IW-1:0] node_idx_in, mem_req_out;
        logic [3*D-1:0] mem_bus_in;
        logic [IW:0]   node_idx_out;
        logic [D-1:0]  data_out;
        exp_t          q[$];
        bit            mon_active, lane_done, lane_done2;

        tree_stage_param #(
            .SAMPLE_SIZE(SS),
            .NUM_NODES  (NN),
            .DATA_SIZE  (D),
            .MEM_LATENCY(ML),
            .LEAF       (int'(LF)),
            .SIGNED_CMP (int'(SG))
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .memRdy     (mem_rdy),
            .validIdx   (valid_idx),
            .validSamp  (valid_samp),
            .received   (received),
            .samplesIn  (samples_in),
            .nodeIdxIn  (node_idx_in),
            .memReqOut  (mem_req_out),
            .memReqValid(mem_req_valid),
            .memBusIn   (mem_bus_in),
            .samplesOut (samples_out),
            .nodeIdxOut (node_idx_out),
            .dataOut    (data_out),
            .errIdx     (err_idx),
            .validBottom(valid_bottom),
            .validRight (valid_right),
            .bottomRec  (bottom_rec),
            .rightRec   (right_rec)
        );

        assign zero_v[g] = !(received | mem_req_valid | valid_bottom | valid_right | err_idx)
                           && mem_req_out == '0 && node_idx_out == '0 && data_out == '0
                           && samples_out == '0;
        assign done_v[g]  = lane_done;
        assign done2_v[g] = lane_done2;

        // Reference: plain integer arithmetic on the record fields.
        function automatic exp_t model(input logic [SW-1:0] s, input logic [IW-1:0] idx,
                                       input logic [D-1:0] sidx, input logic [D-1:0] mid,
                                       input logic [D-1:0] off);
            exp_t e;
            int cur, m, o;
            logic [D-1:0] v;
            e.samp = s;
            e.cyc  = 0;
            e.err  = (int'(sidx) >= SS);
            v = '0;
            if (!e.err) v = s[int'(sidx)*D +: D];
            cur = SG ? int'($signed(v)) : int'(v);
            m   = SG ? int'($signed(mid)) : int'(mid);
            o   = SG ? int'($signed(off)) : int'(off);
            e.data = LF ? D'(cur * m + o) : '0;
            e.idx  = LF ? '0 : {idx, cur > m};
            return e;
        endfunction

        task automatic run_item(input logic [SW-1:0] s, input logic [IW-1:0] idx,
                                input logic [D-1:0] sidx, input logic [D-1:0] mid,
                                input logic [D-1:0] off, input int stall);
            exp_t e;
            int k;
            logic [3*D-1:0] rec;
            rec = {sidx, mid, off};
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                mem_rdy = 0; valid_idx = 1; valid_samp = 1;
                samples_in = s; node_idx_in = idx; mem_bus_in = 24'($urandom);
                #1 check($sformatf("l%0d_stall_received", g), received, 0);
            end
            @(negedge clk);
            mem_rdy = 1; valid_idx = 1; valid_samp = 1; samples_in = s; node_idx_in = idx;
            mem_bus_in = (ML == 0) ? rec : 24'($urandom);
            #1;
            k = 0;
            while (!received && k < 300) begin
                @(negedge clk);
                #1;
                k++;
            end
            if (!received) begin
                fail($sformatf("l%0d_accept_timeout", g));
                valid_idx = 0; valid_samp = 0;
                return;
            end
            check($sformatf("l%0d_req_valid", g), mem_req_valid, 1);
            check($sformatf("l%0d_req_addr", g), mem_req_out, idx);
            e = model(s, idx, sidx, mid, off);
            e.cyc = cyc + ML + 1;
            q.push_back(e);
            for (int t = 1; t <= ML; t++) begin
                @(negedge clk);
                valid_idx = 0; valid_samp = 0; samples_in = ~s; node_idx_in = ~idx;
                mem_bus_in = (t == ML) ? rec : 24'($urandom);
                #1 check($sformatf("l%0d_received_pulse", g), received, 0);
            end
            @(negedge clk);
            valid_idx = 0; valid_samp = 0; samples_in = ~s; node_idx_in = ~idx;
            mem_bus_in = 24'($urandom);
        endtask

        task automatic drain(input string name);
            int k;
            k = 0;
            while ((q.size() != 0 || mon_active) && k < 500) begin
                @(negedge clk);
                k++;
            end
            if (q.size() != 0 || mon_active) fail($sformatf("l%0d_%s", g, name));
        endtask

        initial begin : drv
            logic [SW-1:0] s;
            mem_rdy = 0; valid_idx = 0; valid_samp = 0;
            samples_in = '0; node_idx_in = '0; mem_bus_in = '0;
            lane_done = 0; lane_done2 = 0;
            @(negedge clk);
            while (rst) @(negedge clk);
            for (int i = 0; i < 6; i++) begin
                s = {$urandom, $urandom};
                if (D_SIDX[i] < SS) s[int'(D_SIDX[i])*D +: D] = D_VAL[i];
                run_item(s, D_IDX[i], D_SIDX[i], D_MID[i], D_OFF[i], i % 2);
            end
            for (int i = 0; i < 40; i++)
                run_item({$urandom, $urandom}, IW'($urandom), D'($urandom_range(0, 9)),
                         D'($urandom), D'($urandom), $urandom_range(0, 2));
            drain("drain");
            lane_done = 1;
            wait (rst_go);
            @(negedge clk);
            mem_rdy = 1; valid_idx = 1; valid_samp = 1;
            node_idx_in = IW'($urandom); samples_in = {$urandom, $urandom};
            #1 check($sformatf("l%0d_accept_before_reset", g), received, 1);
            @(negedge clk);
            valid_idx = 0; valid_samp = 0;
            wait (rst);
            wait (!rst);
            @(negedge clk);
            for (int i = 0; i < 4; i++)
                run_item({$urandom, $urandom}, IW'($urandom), D'($urandom_range(0, 9)),
                         D'($urandom), D'($urandom), $urandom_range(0, 1));
            drain("drain_after_reset");
            lane_done2 = 1;
        end

        initial begin : mon
            exp_t e;
            bit bt, rt, br, rr;
            mon_active = 0; bt = 0; rt = 0; bottom_rec = 0; right_rec = 0;
            forever begin
                @(negedge clk);
                #2;
                br = ($urandom_range(0, 2) == 0);
                rr = ($urandom_range(0, 2) == 0);
                if (valid_bottom || valid_right) begin
                    if (!mon_active) begin
                        if (q.size() == 0) begin
                            fail($sformatf("l%0d_unexpected_output", g));
                        end else begin
                            e = q.pop_front();
                            mon_active = 1; bt = 0; rt = 0;
                            check($sformatf("l%0d_latency", g), cyc, e.cyc);
                        end
                    end
                    if (mon_active) begin
                        check($sformatf("l%0d_node_idx", g), node_idx_out, e.idx);
                        check($sformatf("l%0d_data", g), data_out, e.data);
                        check($sformatf("l%0d_err_idx", g), err_idx, e.err);
                        check($sformatf("l%0d_samples", g), samples_out, e.samp);
                        check($sformatf("l%0d_valid_bottom", g), valid_bottom, !bt);
                        check($sformatf("l%0d_valid_right", g), valid_right, !rt);
                        if (valid_bottom && br) bt = 1;
                        if (valid_right && rr) rt = 1;
                        if (bt && rt) mon_active = 0;
                    end
                end else if (mon_active) begin
                    fail($sformatf("l%0d_valid_dropped_early", g));
                    mon_active = 0;
                end
                bottom_rec = br;
                right_rec  = rr;
            end
        end
    end

    initial begin : main
        int k;
        rst_init = 1; rst_mid = 0; rst_go = 0;
        repeat (3) @(negedge clk);
        #1;
        for (int i = 0; i < NL; i++) check($sformatf("l%0d_reset_outputs", i), zero_v[i], 1);
        rst_init = 0;
        k = 0;
        while (!(&done_v) && k < 40000) begin
            @(negedge clk);
            k++;
        end
        if (!(&done_v)) begin
            fail("lanes_done");
        end else begin
            @(negedge clk);
            #3 rst_go = 1;
            @(negedge clk);
            @(negedge clk);
            #1 rst_mid = 1;
            #1;
            for (int i = 0; i < NL; i++) check($sformatf("l%0d_mid_reset_outputs", i), zero_v[i], 1);
            @(negedge clk);
            @(negedge clk);
            rst_mid = 0;
            #1;
            for (int i = 0; i < NL; i++) check($sformatf("l%0d_post_release", i), zero_v[i], 1);
            k = 0;
            while (!(&done2_v) && k < 5000) begin
                @(negedge clk);
                k++;
            end
            if (!(&done2_v)) fail("lanes_done_after_reset");
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
